csa_adder_arbiter: RTL and testbench

CSA_ADDER_ARBITER -- requirements
Module: csa_adder_arbiter

---
 rtl/fpu_pkg.sv | 18 +
 rtl/csa_tag_pipe.sv | 33 +++
 rtl/csa_adder_arbiter.sv | 110 +++++++++++
 tb/tb_csa_adder_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the carry-save adder arbiter: FSM encoding and the
// {valid, id} tag that travels alongside the external adder.
package fpu_pkg;

    localparam int ADD_W_DEF = 22;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t OWN0 = 2'd1;
    localparam arb_state_t OWN1 = 2'd2;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/csa_tag_pipe.sv
// Fixed-depth tag shift register that tracks which requester owns each
// sum moving through the external adder; clr empties every stage.
module csa_tag_pipe
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  tag_t din,
    output tag_t dout,
    output logic any_vld
);

    tag_t [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (clr) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_vld = any_vld | pipe[i].valid;
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/csa_adder_arbiter.sv
// Two-requester round-robin arbiter with lockable ownership in front of a
// shared, externally implemented adder of fixed latency ADD_LAT (1..4).
module csa_adder_arbiter
    import fpu_pkg::*;
#(
    parameter int ADD_W   = ADD_W_DEF,
    parameter int ADD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_lock,
    input  logic [1:0][ADD_W-1:0] req_a,
    input  logic [1:0][ADD_W-1:0] req_b,
    output logic                  add_valid,
    output logic [ADD_W-1:0]      add_a,
    output logic [ADD_W-1:0]      add_b,
    input  logic [ADD_W:0]        add_s,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [ADD_W:0]        rsp_sum,
    output logic                  busy
);

    arb_state_t state;
    logic       rr_ptr;
    logic [1:0] grant;
    logic       gnt_id;
    logic       xfer;
    logic       add_id;
    tag_t       tag_in;
    tag_t       tag_tail;
    logic       tag_any;

    // Grant is a pure function of state and valids; reset masks it so no
    // handshake can complete while rst is high.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (state)
                IDLE:    grant = (req_valid == 2'b11) ? (rr_ptr ? 2'b10 : 2'b01) : req_valid;
                OWN0:    grant = {1'b0, req_valid[0]};
                OWN1:    grant = {req_valid[1], 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign gnt_id    = grant[1];
    assign xfer      = |grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else if (xfer) begin
            state <= req_lock[gnt_id] ? (gnt_id ? OWN1 : OWN0) : IDLE;
            // Fairness pointer only moves on open arbitration, not while owned.
            if (state == IDLE) rr_ptr <= ~gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_valid <= 1'b0;
            add_id    <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            add_valid <= xfer;
            if (xfer) begin
                add_id <= gnt_id;
                add_a  <= req_a[gnt_id];
                add_b  <= req_b[gnt_id];
            end
        end
    end

    assign tag_in = '{valid: add_valid, id: add_id};

    csa_tag_pipe #(
        .DEPTH(ADD_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .clr    (rst),
        .din    (tag_in),
        .dout   (tag_tail),
        .any_vld(tag_any)
    );

    // The tag tail lines up with add_s, so the sum is captured alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= '0;
        end else begin
            rsp_valid <= tag_tail.valid;
            if (tag_tail.valid) begin
                rsp_id  <= tag_tail.id;
                rsp_sum <= add_s;
            end
        end
    end

    assign busy = (state != IDLE) | add_valid | tag_any | rsp_valid;

endmodule

// File: tb/tb_csa_adder_arbiter.sv
// Directed bench for csa_adder_arbiter; three instances (ADD_LAT 2, 1, 4)
// share stimulus, each fed by its own behavioural adder returning a+b.
module tb_csa_adder_arbiter;

    localparam int W = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_lock  = 2'b00;
    logic [1:0][W-1:0] req_a = '0;
    logic [1:0][W-1:0] req_b = '0;

    logic [1:0]   rdy  [3];
    logic         av   [3];
    logic [W-1:0] aa   [3];
    logic [W-1:0] ab   [3];
    logic [W:0]   sum_in [3];
    logic         rv   [3];
    logic         rid  [3];
    logic [W:0]   rs   [3];
    logic         bsy  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_adder_arbiter #(.ADD_W(W), .ADD_LAT(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_lock(req_lock),
        .req_a(req_a), .req_b(req_b), .add_valid(av[0]), .add_a(aa[0]), .add_b(ab[0]),
        .add_s(sum_in[0]), .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_sum(rs[0]), .busy(bsy[0]));

    csa_adder_arbiter #(.ADD_W(W), .ADD_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_lock(req_lock),
        .req_a(req_a), .req_b(req_b), .add_valid(av[1]), .add_a(aa[1]), .add_b(ab[1]),
        .add_s(sum_in[1]), .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_sum(rs[1]), .busy(bsy[1]));

    csa_adder_arbiter #(.ADD_W(W), .ADD_LAT(4)) dut_l4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_lock(req_lock),
        .req_a(req_a), .req_b(req_b), .add_valid(av[2]), .add_a(aa[2]), .add_b(ab[2]),
        .add_s(sum_in[2]), .rsp_valid(rv[2]), .rsp_id(rid[2]), .rsp_sum(rs[2]), .busy(bsy[2]));

    // External adders: sum of the operands presented ADD_LAT cycles earlier.
    logic [W:0] p2 [2];
    logic [W:0] p1 [1];
    logic [W:0] p4 [4];

    always @(posedge clk) begin
        p2[0] <= {1'b0, aa[0]} + {1'b0, ab[0]};
        p2[1] <= p2[0];
        p1[0] <= {1'b0, aa[1]} + {1'b0, ab[1]};
        p4[0] <= {1'b0, aa[2]} + {1'b0, ab[2]};
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end

    assign sum_in[0] = p2[1];
    assign sum_in[1] = p1[0];
    assign sum_in[2] = p4[3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        req_lock = 2'b00;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        step();
        step();
        #1;
        checks++;
        if (rdy[0] !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", rdy[0]);
        end
        checks++;
        if (av[0] !== 1'b0 || aa[0] !== '0 || ab[0] !== '0) begin
            errors++; $display("FAIL reset_add got v=%b a=%h b=%h exp 0 0 0", av[0], aa[0], ab[0]);
        end
        checks++;
        if (rv[0] !== 1'b0 || rid[0] !== 1'b0 || rs[0] !== '0 || bsy[0] !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got v=%b id=%b s=%h busy=%b exp all 0", rv[0], rid[0], rs[0], bsy[0]);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        req_a[0] = 22'h3FFFFF;
        req_b[0] = 22'h000001;
        #1;
        checks++;
        if (rdy[0] !== 2'b01) begin
            errors++; $display("FAIL single_ready got %b exp 01", rdy[0]);
        end
        step();
        req_valid = 2'b00;
        checks++;
        if (av[0] !== 1'b1 || aa[0] !== 22'h3FFFFF || ab[0] !== 22'h000001) begin
            errors++; $display("FAIL single_add got v=%b a=%h b=%h exp 1 3fffff 000001", av[0], aa[0], ab[0]);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (rv[0] !== 1'b0) begin
                errors++; $display("FAIL single_early_rsp cycle %0d got %b exp 0", i, rv[0]);
            end
            step();
        end
        checks++;
        if (rv[0] !== 1'b1 || rid[0] !== 1'b0 || rs[0] !== 23'h400000) begin
            errors++; $display("FAIL single_rsp got v=%b id=%b s=%h exp 1 0 400000", rv[0], rid[0], rs[0]);
        end
        step();
        checks++;
        if (rv[0] !== 1'b0 || bsy[0] !== 1'b0) begin
            errors++; $display("FAIL single_done got v=%b busy=%b exp 0 0", rv[0], bsy[0]);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        do_reset();
        req_a[0] = 22'd1;  req_b[0] = 22'd2;
        req_a[1] = 22'd10; req_b[1] = 22'd20;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rdy[0] !== exp_g[i]) begin
                errors++; $display("FAIL contention_grant %0d got %b exp %b", i, rdy[0], exp_g[i]);
            end
            step();
        end
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv[0] !== 1'b1 || rid[0] !== i[0] || rs[0] !== (i[0] ? 23'd30 : 23'd3)) begin
                errors++; $display("FAIL contention_rsp %0d got v=%b id=%b s=%0d exp 1 %0d %0d",
                                   i, rv[0], rid[0], rs[0], i % 2, i[0] ? 30 : 3);
            end
            step();
        end
        checks++;
        if (rv[0] !== 1'b0) begin
            errors++; $display("FAIL contention_tail got %b exp 0", rv[0]);
        end
    endtask

    task automatic test_lock();
        logic lk [3];
        lk = '{1'b1, 1'b1, 1'b0};
        do_reset();
        req_a[0] = 22'd5;   req_b[0] = 22'd6;
        req_a[1] = 22'd100; req_b[1] = 22'd200;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            req_lock = {1'b0, lk[i]};
            #1;
            checks++;
            if (rdy[0] !== 2'b01) begin
                errors++; $display("FAIL lock_hold %0d got %b exp 01", i, rdy[0]);
            end
            step();
        end
        req_lock = 2'b00;
        #1;
        checks++;
        if (rdy[0] !== 2'b10) begin
            errors++; $display("FAIL lock_release got %b exp 10", rdy[0]);
        end
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rv[0] !== 1'b1 || rid[0] !== (i == 3) || rs[0] !== ((i == 3) ? 23'd300 : 23'd11)) begin
                errors++; $display("FAIL lock_rsp %0d got v=%b id=%b s=%0d exp 1 %0d %0d",
                                   i, rv[0], rid[0], rs[0], i == 3, (i == 3) ? 300 : 11);
            end
            step();
        end
    endtask

    task automatic test_lock_idle();
        do_reset();
        req_valid = 2'b10;
        req_lock = 2'b10;
        #1;
        checks++;
        if (rdy[0] !== 2'b10) begin
            errors++; $display("FAIL lock_idle_grant got %b exp 10", rdy[0]);
        end
        step();
        req_valid = 2'b00;
        req_lock = 2'b00;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rdy[0] !== 2'b00) begin
                errors++; $display("FAIL lock_idle_quiet %0d got %b exp 00", i, rdy[0]);
            end
            step();
        end
        req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rdy[0] !== 2'b00 || bsy[0] !== 1'b1) begin
                errors++; $display("FAIL lock_idle_block %0d got rdy=%b busy=%b exp 00 1", i, rdy[0], bsy[0]);
            end
            step();
        end
        req_valid = 2'b10;
        #1;
        checks++;
        if (rdy[0] !== 2'b10) begin
            errors++; $display("FAIL lock_idle_owner got %b exp 10", rdy[0]);
        end
        step();
        req_valid = 2'b00;
        repeat (6) step();
        checks++;
        if (bsy[0] !== 1'b0) begin
            errors++; $display("FAIL lock_idle_drain got busy=%b exp 0", bsy[0]);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 2'b01;
        step();
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bsy[0] !== 1'b0) begin
            errors++; $display("FAIL midflight_busy got %b exp 0", bsy[0]);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rv[0] !== 1'b0) begin
                errors++; $display("FAIL midflight_rsp %0d got %b exp 0", i, rv[0]);
            end
            step();
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (rdy[0] !== 2'b01) begin
            errors++; $display("FAIL midflight_rr got %b exp 01", rdy[0]);
        end
        step();
        req_valid = 2'b00;
        repeat (6) step();
    endtask

    // Random valid/lock against a reference arbiter; each instance is
    // checked for grant and for response timing, id and sum per cycle.
    task automatic test_sweep();
        logic       ev   [3][160];
        logic       eid  [3][160];
        logic [W:0] esum [3][160];
        int lat [3];
        int ms;
        logic mr;
        logic [1:0] g;
        int id;
        lat = '{2, 1, 4};
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 160; c++) begin
                ev[k][c] = 1'b0; eid[k][c] = 1'b0; esum[k][c] = '0;
            end
        do_reset();
        ms = 0;
        mr = 1'b0;
        for (int c = 0; c < 136; c++) begin
            if (c < 120) begin
                req_valid = 2'($urandom_range(0, 3));
                req_lock = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
                req_a[0] = W'($urandom); req_b[0] = W'($urandom);
                req_a[1] = W'($urandom); req_b[1] = W'($urandom);
            end else begin
                req_valid = 2'b00;
                req_lock = 2'b00;
            end
            #1;
            if (ms == 0) g = (req_valid == 2'b11) ? (mr ? 2'b10 : 2'b01) : req_valid;
            else if (ms == 1) g = req_valid & 2'b01;
            else g = req_valid & 2'b10;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdy[k] !== g) begin
                    errors++; $display("FAIL sweep_grant lat%0d cyc %0d got %b exp %b", lat[k], c, rdy[k], g);
                end
                checks++;
                if (rv[k] !== ev[k][c] || (ev[k][c] && (rid[k] !== eid[k][c] || rs[k] !== esum[k][c]))) begin
                    errors++; $display("FAIL sweep_rsp lat%0d cyc %0d got v=%b id=%b s=%h exp %b %b %h",
                                       lat[k], c, rv[k], rid[k], rs[k], ev[k][c], eid[k][c], esum[k][c]);
                end
            end
            if (g != 2'b00) begin
                id = g[1] ? 1 : 0;
                for (int k = 0; k < 3; k++) begin
                    ev[k][c + lat[k] + 2] = 1'b1;
                    eid[k][c + lat[k] + 2] = g[1];
                    esum[k][c + lat[k] + 2] = {1'b0, req_a[id]} + {1'b0, req_b[id]};
                end
                if (ms == 0) mr = ~g[1];
                ms = req_lock[id] ? id + 1 : 0;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_lock_idle();
        test_reset_midflight();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
